// File: rtl/ysyx_23060077_ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the PC, issues single-outstanding AR/R reads and
// hands instructions to the IDU, stalling on control transfers until the EXU redirects.

module ysyx_23060077_pre_decode #(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic              jump
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [INST_W-1:0] INST_ECALL = INST_W'(32'h0000_0073);
  localparam logic [INST_W-1:0] INST_MRET  = INST_W'(32'h3020_0073);

  logic [6:0] opcode;

  assign opcode = inst[6:0];

  // Only ecall/mret change flow among SYSTEM ops; CSR accesses fall through.
  always_comb begin
    jump = 1'b0;
    case (opcode)
      OP_BRANCH, OP_JAL, OP_JALR: jump = 1'b1;
      default:                    jump = (inst == INST_ECALL) || (inst == INST_MRET);
    endcase
  end

endmodule

module ysyx_23060077_ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arvalid,
  input  logic              ifu_arready,
  input  logic [INST_W-1:0] ifu_rdata,
  input  logic [1:0]        ifu_rresp,
  input  logic              ifu_rvalid,
  output logic              ifu_rready,
  output logic              ifu_valid,
  output logic [INST_W-1:0] ifu_inst,
  output logic [ADDR_W-1:0] ifu_pc,
  output logic              ifu_jump,
  input  logic              idu_ready,
  input  logic              exu_redirect_valid,
  input  logic [ADDR_W-1:0] exu_redirect_pc,
  output logic              ifu_fetch_err
);

  typedef enum logic [2:0] {
    REQ      = 3'd0,
    WAIT_R   = 3'd1,
    HOLD     = 3'd2,
    WAIT_JMP = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              dec_jump;

  assign ifu_araddr = pc;

  ysyx_23060077_pre_decode #(
    .INST_W(INST_W)
  ) u_pre_decode (
    .inst(ifu_rdata),
    .jump(dec_jump)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= REQ;
      pc            <= ADDR_W'(RESET_PC);
      ifu_arvalid   <= 1'b0;
      ifu_rready    <= 1'b0;
      ifu_valid     <= 1'b0;
      ifu_inst      <= '0;
      ifu_pc        <= '0;
      ifu_jump      <= 1'b0;
      ifu_fetch_err <= 1'b0;
    end else begin
      case (state)
        // Raise arvalid one cycle after entering REQ; hold address until accepted.
        REQ: begin
          if (ifu_arvalid && ifu_arready) begin
            ifu_arvalid <= 1'b0;
            ifu_rready  <= 1'b1;
            state       <= WAIT_R;
          end else begin
            ifu_arvalid <= 1'b1;
          end
        end
        WAIT_R: begin
          if (ifu_rvalid && ifu_rready) begin
            ifu_rready <= 1'b0;
            if (ifu_rresp == 2'b00) begin
              ifu_inst  <= ifu_rdata;
              ifu_pc    <= pc;
              ifu_jump  <= dec_jump;
              ifu_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              ifu_fetch_err <= 1'b1;
              state         <= ERR;
            end
          end
        end
        // A jump keeps pc frozen; the EXU supplies the real successor.
        HOLD: begin
          if (ifu_valid && idu_ready) begin
            ifu_valid <= 1'b0;
            if (ifu_jump) begin
              state <= WAIT_JMP;
            end else begin
              pc    <= pc + ADDR_W'(4);
              state <= REQ;
            end
          end
        end
        WAIT_JMP: begin
          if (exu_redirect_valid) begin
            pc    <= exu_redirect_pc;
            state <= REQ;
          end
        end
        ERR: begin
          ifu_arvalid   <= 1'b0;
          ifu_rready    <= 1'b0;
          ifu_valid     <= 1'b0;
          ifu_fetch_err <= 1'b1;
        end
        default: begin
          ifu_arvalid   <= 1'b0;
          ifu_rready    <= 1'b0;
          ifu_valid     <= 1'b0;
          ifu_fetch_err <= 1'b1;
          state         <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_ifu_fetch_ctrl.sv
// Directed bench for the IFU fetch sequencer: reset, sequential fetch, backpressure,
// jump stall/redirect, system instructions, PC wrap, fetch error and reset during read.

module tb_ysyx_23060077_ifu_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        ifu_jump;
  logic        idu_ready;
  logic        exu_redirect_valid;
  logic [31:0] exu_redirect_pc;
  logic        ifu_fetch_err;

  int checks = 0;
  int errors = 0;

  ysyx_23060077_ifu_fetch_ctrl #(
    .RESET_PC(32'h3000_0000),
    .ADDR_W  (32),
    .INST_W  (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ifu_araddr        (ifu_araddr),
    .ifu_arvalid       (ifu_arvalid),
    .ifu_arready       (ifu_arready),
    .ifu_rdata         (ifu_rdata),
    .ifu_rresp         (ifu_rresp),
    .ifu_rvalid        (ifu_rvalid),
    .ifu_rready        (ifu_rready),
    .ifu_valid         (ifu_valid),
    .ifu_inst          (ifu_inst),
    .ifu_pc            (ifu_pc),
    .ifu_jump          (ifu_jump),
    .idu_ready         (idu_ready),
    .exu_redirect_valid(exu_redirect_valid),
    .exu_redirect_pc   (exu_redirect_pc),
    .ifu_fetch_err     (ifu_fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for arvalid, accepts the address, then returns one R beat.
  task automatic fetch_word(input logic [31:0] word, input logic [1:0] resp,
                            output logic [31:0] addr, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifu_arvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    addr = ifu_araddr;
    if (ok) begin
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b1;
      ifu_rdata   = word;
      ifu_rresp   = resp;
      tick();
      ifu_rvalid  = 1'b0;
      ifu_rresp   = 2'b00;
    end
  endtask

  task automatic handoff();
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if ({ifu_arvalid, ifu_rready, ifu_valid, ifu_jump, ifu_fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {ifu_arvalid, ifu_rready, ifu_valid, ifu_jump, ifu_fetch_err}); end
    checks++; if (ifu_inst !== 32'h0 || ifu_pc !== 32'h0) begin
      errors++; $display("FAIL reset_data got inst=%h pc=%h exp 0/0", ifu_inst, ifu_pc); end
    checks++; if (ifu_araddr !== 32'h3000_0000) begin
      errors++; $display("FAIL reset_araddr got %h exp 30000000", ifu_araddr); end
    reset = 1'b1;
    tick();
    checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h3000_0000) begin
      errors++; $display("FAIL first_ar got v=%b a=%h exp 1/30000000", ifu_arvalid, ifu_araddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic ok;
    fetch_word(32'h0000_0013, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0000) begin
      errors++; $display("FAIL seq_addr got ok=%b a=%h exp 30000000", ok, a); end
    checks++; if (ifu_valid !== 1'b1 || ifu_pc !== 32'h3000_0000 || ifu_inst !== 32'h13 || ifu_jump !== 1'b0) begin
      errors++; $display("FAIL seq_out got v=%b pc=%h inst=%h j=%b exp 1/30000000/00000013/0", ifu_valid, ifu_pc, ifu_inst, ifu_jump); end
    handoff();
    checks++; if (ifu_valid !== 1'b0 || ifu_araddr !== 32'h3000_0004) begin
      errors++; $display("FAIL seq_next got v=%b a=%h exp 0/30000004", ifu_valid, ifu_araddr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic ok;
    fetch_word(32'h0010_0093, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0004) begin
      errors++; $display("FAIL bp_addr got ok=%b a=%h exp 30000004", ok, a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h0010_0093 || ifu_pc !== 32'h3000_0004 || ifu_arvalid !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b inst=%h pc=%h arv=%b exp 1/00100093/30000004/0", i, ifu_valid, ifu_inst, ifu_pc, ifu_arvalid); end
    end
    handoff();
    checks++; if (ifu_araddr !== 32'h3000_0008) begin
      errors++; $display("FAIL bp_next got %h exp 30000008", ifu_araddr); end
  endtask

  task automatic test_jump();
    logic [31:0] a;
    logic ok;
    fetch_word(32'h0080_006F, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0008 || ifu_jump !== 1'b1) begin
      errors++; $display("FAIL jal_fetch got ok=%b a=%h j=%b exp 30000008/1", ok, a, ifu_jump); end
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h1234_5678;
    tick();
    exu_redirect_valid = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_araddr !== 32'h3000_0008) begin
      errors++; $display("FAIL jal_hold_redirect got v=%b a=%h exp 1/30000008", ifu_valid, ifu_araddr); end
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h5555_5554;
    handoff();
    exu_redirect_valid = 1'b0;
    checks++; if (ifu_valid !== 1'b0 || ifu_araddr !== 32'h3000_0008) begin
      errors++; $display("FAIL jal_handoff_redirect got v=%b a=%h exp 0/30000008", ifu_valid, ifu_araddr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifu_arvalid !== 1'b0) begin
        errors++; $display("FAIL jal_stall cyc=%0d got arvalid=%b exp 0", i, ifu_arvalid); end
    end
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = 32'h3000_0010;
    tick();
    exu_redirect_valid = 1'b0;
    checks++; if (ifu_araddr !== 32'h3000_0010) begin
      errors++; $display("FAIL jal_redirect_addr got %h exp 30000010", ifu_araddr); end
    tick();
    checks++; if (ifu_arvalid !== 1'b1) begin
      errors++; $display("FAIL jal_redirect_ar got %b exp 1", ifu_arvalid); end
  endtask

  task automatic redirect(input logic [31:0] target);
    exu_redirect_valid = 1'b1;
    exu_redirect_pc    = target;
    tick();
    exu_redirect_valid = 1'b0;
  endtask

  task automatic test_system();
    logic [31:0] a;
    logic ok;
    fetch_word(32'h3020_0073, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0010 || ifu_jump !== 1'b1) begin
      errors++; $display("FAIL mret got ok=%b a=%h j=%b exp 30000010/1", ok, a, ifu_jump); end
    handoff();
    tick();
    checks++; if (ifu_arvalid !== 1'b0) begin
      errors++; $display("FAIL mret_stall got arvalid=%b exp 0", ifu_arvalid); end
    redirect(32'h3000_0020);
    fetch_word(32'h0000_0073, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0020 || ifu_jump !== 1'b1) begin
      errors++; $display("FAIL ecall got ok=%b a=%h j=%b exp 30000020/1", ok, a, ifu_jump); end
    handoff();
    redirect(32'h3000_0030);
    fetch_word(32'h0000_8067, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'h3000_0030 || ifu_jump !== 1'b1) begin
      errors++; $display("FAIL jalr got ok=%b a=%h j=%b exp 30000030/1", ok, a, ifu_jump); end
    handoff();
    redirect(32'hFFFF_FFFC);
    fetch_word(32'h3052_9073, 2'b00, a, ok);
    checks++; if (!ok || a !== 32'hFFFF_FFFC || ifu_jump !== 1'b0) begin
      errors++; $display("FAIL csrrw got ok=%b a=%h j=%b exp fffffffc/0", ok, a, ifu_jump); end
    handoff();
    checks++; if (ifu_araddr !== 32'h0000_0000) begin
      errors++; $display("FAIL pc_wrap got %h exp 00000000", ifu_araddr); end
  endtask

  task automatic test_error();
    logic [31:0] a;
    logic ok;
    fetch_word(32'h0000_0013, 2'b10, a, ok);
    checks++; if (!ok || a !== 32'h0 || ifu_fetch_err !== 1'b1 || ifu_valid !== 1'b0) begin
      errors++; $display("FAIL err_set got ok=%b a=%h err=%b v=%b exp 00000000/1/0", ok, a, ifu_fetch_err, ifu_valid); end
    ifu_arready = 1'b1;
    idu_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifu_rvalid = i[0];
      tick();
      checks++; if (ifu_arvalid !== 1'b0 || ifu_valid !== 1'b0 || ifu_rready !== 1'b0 || ifu_fetch_err !== 1'b1) begin
        errors++; $display("FAIL err_stuck cyc=%0d got arv=%b v=%b rr=%b err=%b exp 0/0/0/1", i, ifu_arvalid, ifu_valid, ifu_rready, ifu_fetch_err); end
    end
    ifu_arready = 1'b0;
    idu_ready   = 1'b0;
    ifu_rvalid  = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (ifu_fetch_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b exp 0", ifu_fetch_err); end
    reset = 1'b1;
    tick();
    checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h3000_0000) begin
      errors++; $display("FAIL err_refetch got v=%b a=%h exp 1/30000000", ifu_arvalid, ifu_araddr); end
  endtask

  task automatic test_reset_mid_read();
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    checks++; if (ifu_rready !== 1'b1) begin
      errors++; $display("FAIL midr_rready got %b exp 1", ifu_rready); end
    ifu_rvalid = 1'b1;
    ifu_rdata  = 32'h0000_0013;
    reset      = 1'b0;
    tick();
    checks++; if (ifu_valid !== 1'b0 || ifu_inst !== 32'h0 || ifu_rready !== 1'b0) begin
      errors++; $display("FAIL midr_discard got v=%b inst=%h rr=%b exp 0/0/0", ifu_valid, ifu_inst, ifu_rready); end
    ifu_rvalid = 1'b0;
    reset      = 1'b1;
    tick();
    checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h3000_0000) begin
      errors++; $display("FAIL midr_refetch got v=%b a=%h exp 1/30000000", ifu_arvalid, ifu_araddr); end
  endtask

  initial begin
    reset              = 1'b0;
    ifu_arready        = 1'b0;
    ifu_rdata          = 32'h0;
    ifu_rresp          = 2'b00;
    ifu_rvalid         = 1'b0;
    idu_ready          = 1'b0;
    exu_redirect_valid = 1'b0;
    exu_redirect_pc    = 32'h0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_system();
    test_error();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
